// File: rtl/fb_row_fetcher_pkg.sv
// Shared types and geometry for the framebuffer row fetcher.
// Panel geometry and RAM port B widths; the fetch FSM state and FIFO beat layout.
package fb_row_fetcher_pkg;

    localparam int PIXEL_WIDTH      = 64;
    localparam int PIXEL_HEIGHT     = 32;
    localparam int PIXEL_HALFHEIGHT = 16;
    localparam int BYTES_PER_PIXEL  = 2;
    localparam int RAM_LATENCY_DEF  = 1;

    localparam int ROW_W        = $clog2(PIXEL_HALFHEIGHT);
    localparam int COL_W        = $clog2(PIXEL_WIDTH);
    localparam int RAM_B_ADDR_W = $clog2(PIXEL_HALFHEIGHT * PIXEL_WIDTH);
    localparam int RAM_B_DATA_W = (PIXEL_HEIGHT / PIXEL_HALFHEIGHT) * BYTES_PER_PIXEL * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [RAM_B_DATA_W-1:0] data;
        logic [COL_W-1:0]        col;
    } fetch_beat_t;

endpackage

// File: rtl/fb_fetch_skid_fifo.sv
// Small circular FIFO that absorbs RAM read latency in front of the pixel stream.
// Push and pop in the same cycle are both honoured; the head is visible combinationally.
module fb_fetch_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fb_row_fetcher.sv
// Walks one row-pair of the framebuffer through RAM port B and streams it as valid/ready beats.
// Define FB_FETCH_MIRROR_EN to issue columns from PIXEL_WIDTH-1 down to 0 for mirrored panels.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads, gated by credits (outstanding + queued)
// DRAIN | all reads issued, streaming out remaining beats
module fb_row_fetcher
    import fb_row_fetcher_pkg::*;
#(
    parameter int RAM_LATENCY = RAM_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ROW_W-1:0]        row_sel,
    output logic                    busy,
    output logic                    done,
    output logic [RAM_B_ADDR_W-1:0] ram_addr,
    output logic                    ram_clk_en,
    input  logic [RAM_B_DATA_W-1:0] ram_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [RAM_B_DATA_W-1:0] pix_data,
    output logic [COL_W-1:0]        pix_col,
    output logic                    pix_last
);
    localparam int FIFO_DEPTH = RAM_LATENCY + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

`ifdef FB_FETCH_MIRROR_EN
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(PIXEL_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_FINAL = '0;
`else
    localparam logic [COL_W-1:0] COL_FIRST = '0;
    localparam logic [COL_W-1:0] COL_FINAL = COL_W'(PIXEL_WIDTH - 1);
`endif

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_step;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] w_used;
    logic [CNT_W-1:0] w_fifo_count;
    logic [RAM_LATENCY-1:0] r_tag_vld;
    logic [COL_W-1:0] r_tag_col [RAM_LATENCY];
    logic             r_done;
    logic             w_issue;
    logic             w_ret;
    logic             w_pop;
    logic             w_empty;
    fetch_beat_t      w_push_beat;
    fetch_beat_t      w_head;

`ifdef FB_FETCH_MIRROR_EN
    assign w_col_step = r_col - 1'b1;
`else
    assign w_col_step = r_col + 1'b1;
`endif

    assign w_ret       = r_tag_vld[RAM_LATENCY-1];
    assign w_pop       = pix_valid && pix_ready;
    assign w_push_beat = '{data: ram_data, col: r_tag_col[RAM_LATENCY-1]};

    // A slot being popped this cycle is already free, which keeps 1 beat/clk with ready high.
    always_comb begin
        w_used      = r_outstanding + w_fifo_count - CNT_W'(w_pop);
        w_issue     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = FETCH;
            end
            FETCH: begin
                w_issue = (w_used < CNT_W'(FIFO_DEPTH));
                if (w_issue && (r_col == COL_FINAL)) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_pop && pix_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_outstanding <= '0;
            r_tag_vld     <= '0;
            r_done        <= 1'b0;
            for (int i = 0; i < RAM_LATENCY; i++) r_tag_col[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == DRAIN) && w_pop && pix_last;
            if ((r_state == IDLE) && start) begin
                r_row <= row_sel;
                r_col <= COL_FIRST;
            end else if (w_issue) begin
                r_col <= w_col_step;
            end
            r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_ret);
            r_tag_vld[0]  <= w_issue;
            r_tag_col[0]  <= r_col;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_col[i] <= r_tag_col[i-1];
            end
        end
    end

    fb_fetch_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_beat_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_ret),
        .i_din   (w_push_beat),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign ram_clk_en = w_issue;
    assign ram_addr   = {r_row, r_col};
    assign pix_valid  = !w_empty;
    assign pix_data   = w_head.data;
    assign pix_col    = w_head.col;
    assign pix_last   = pix_valid && (w_head.col == COL_FINAL);

endmodule

// File: tb/tb_fb_row_fetcher.sv
// Directed bench for fb_row_fetcher: a RAM_LATENCY=1 instance and a RAM_LATENCY=3 instance,
// each behind a behavioural RAM model, observed through one shared negedge monitor.
module tb_fb_row_fetcher;
    import fb_row_fetcher_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, row_sel_dummy;
    logic [3:0]  row_sel;
    logic        start1, start3, pix_ready1, pix_ready3;
    logic        busy1, done1, en1, valid1, last1;
    logic        busy3, done3, en3, valid3, last3;
    logic [9:0]  addr1, addr3;
    logic [31:0] q1, q3a, q3b, q3c, data1, data3;
    logic [5:0]  col1, col3;
    logic [31:0] mem [1024];

    fb_row_fetcher #(.RAM_LATENCY(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start1), .row_sel(row_sel),
        .busy(busy1), .done(done1), .ram_addr(addr1), .ram_clk_en(en1), .ram_data(q1),
        .pix_valid(valid1), .pix_ready(pix_ready1), .pix_data(data1), .pix_col(col1), .pix_last(last1));

    fb_row_fetcher #(.RAM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .row_sel(row_sel),
        .busy(busy3), .done(done3), .ram_addr(addr3), .ram_clk_en(en3), .ram_data(q3c),
        .pix_valid(valid3), .pix_ready(pix_ready3), .pix_data(data3), .pix_col(col3), .pix_last(last3));

    always @(posedge clk) if (en1) q1 <= mem[addr1];
    always @(posedge clk) begin
        if (en3) q3a <= mem[addr3];
        q3b <= q3a;
        q3c <= q3b;
    end

    function automatic logic [31:0] exp_word(input logic [3:0] row, input logic [5:0] col);
        if (row == 4'd3 && col == 6'd0)  return 32'hA1B2C3D4;
        if (row == 4'd3 && col == 6'd63) return 32'h0F0E0D0C;
        return {4'hA, row, 2'b01, col, ~{4'h5, row, 2'b10, col}};
    endfunction

    function automatic logic [5:0] exp_col(input int i);
`ifdef FB_FETCH_MIRROR_EN
        return 6'(63 - i);
`else
        return 6'(i);
`endif
    endfunction

    // Monitor: muxed onto whichever instance the current test drives.
    logic        sel3 = 1'b0;
    logic        m_valid, m_ready, m_last, m_busy, m_done, m_en;
    logic [31:0] m_data;
    logic [5:0]  m_col;
    logic [9:0]  m_addr;
    assign m_valid = sel3 ? valid3 : valid1;
    assign m_ready = sel3 ? pix_ready3 : pix_ready1;
    assign m_last  = sel3 ? last3 : last1;
    assign m_busy  = sel3 ? busy3 : busy1;
    assign m_done  = sel3 ? done3 : done1;
    assign m_en    = sel3 ? en3 : en1;
    assign m_data  = sel3 ? data3 : data1;
    assign m_col   = sel3 ? col3 : col1;
    assign m_addr  = sel3 ? addr3 : addr1;

    logic [31:0] qd[$];
    logic [5:0]  qc[$];
    logic        ql[$];
    int tneg = 0, t_start, t_valid, t_last, t_done;
    int n_done, n_issue, n_busy_low, n_unstable;
    logic        stalled, mon_active;
    logic [31:0] stall_data;
    logic [5:0]  stall_col;
    logic [9:0]  first_addr;
    int checks = 0, errors = 0;
    logic [3:0] pat = 4'b1001;

    always @(negedge clk) begin
        tneg++;
        if (m_done) begin
            n_done++;
            if (t_done < 0) t_done = tneg;
        end
        if (mon_active && !m_busy && n_done == 0) n_busy_low++;
        if (m_en) begin
            if (n_issue == 0) first_addr = m_addr;
            n_issue++;
        end
        if (m_valid && t_valid < 0) t_valid = tneg;
        if (stalled && (m_data !== stall_data || m_col !== stall_col)) n_unstable++;
        stalled    = m_valid && !m_ready;
        stall_data = m_data;
        stall_col  = m_col;
        if (m_valid && m_ready) begin
            qd.push_back(m_data);
            qc.push_back(m_col);
            ql.push_back(m_last);
            if (m_last) t_last = tneg;
        end
    end

    task automatic mon_clear();
        qd.delete(); qc.delete(); ql.delete();
        n_done = 0; n_issue = 0; n_busy_low = 0; n_unstable = 0;
        stalled = 1'b0; mon_active = 1'b0; first_addr = '0;
        t_valid = -1; t_last = -1; t_done = -1;
    endtask

    function automatic int count_bad(input logic [3:0] row);
        int bad = 0;
        for (int i = 0; i < qd.size(); i++)
            if (qd[i] !== exp_word(row, exp_col(i)) || qc[i] !== exp_col(i) || ql[i] !== (i == 63)) bad++;
        return bad;
    endfunction

    task automatic set_ready(input logic v);
        if (sel3) pix_ready3 = v; else pix_ready1 = v;
    endtask

    task automatic pulse_start(input logic [3:0] row);
        @(posedge clk); #1;
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        row_sel = row;
        t_start = tneg + 1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0; mon_active = 1'b1;
    endtask

    task automatic wait_done(input int mode, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (n_done != 0) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            set_ready(mode == 0 ? 1'b1 : pat[c % 4]);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if ({busy1, done1, en1, valid1, last1} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy1, done1, en1, valid1, last1}); end
        checks++; if (addr1 !== 10'h0) begin errors++; $display("FAIL reset_addr: got %h expected 000", addr1); end
        checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data1); end
        checks++; if (col1 !== 6'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", col1); end
    endtask

    task automatic test_full_row();
        bit ok;
        mon_clear();
        set_ready(1'b1);
        pulse_start(4'd3);
        wait_done(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout: done not seen"); end
        checks++; if (qd.size() != 64) begin errors++; $display("FAIL full_beats: got %0d expected 64", qd.size()); end
        checks++; if (count_bad(4'd3) != 0) begin errors++; $display("FAIL full_content: %0d bad beats expected 0", count_bad(4'd3)); end
`ifndef FB_FETCH_MIRROR_EN
        checks++; if (qd.size() > 0 && qd[0] !== 32'hA1B2C3D4) begin errors++; $display("FAIL full_first: got %h expected a1b2c3d4", qd[0]); end
        checks++; if (qd.size() == 64 && (qd[63] !== 32'h0F0E0D0C || ql[63] !== 1'b1)) begin errors++; $display("FAIL full_last: got %h/%b expected 0f0e0d0c/1", qd[63], ql[63]); end
`endif
        // Counted in negedges: start is seen at index 0, its edge follows it.
        checks++; if (t_valid - t_start != 3) begin errors++; $display("FAIL full_first_lat: got %0d expected 3", t_valid - t_start); end
        checks++; if (t_last - t_start != 66) begin errors++; $display("FAIL full_last_lat: got %0d expected 66", t_last - t_start); end
        checks++; if (t_done - t_last != 1) begin errors++; $display("FAIL full_done_lat: got %0d expected 1", t_done - t_last); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL full_done_cnt: got %0d expected 1", n_done); end
        checks++; if (n_issue != 64) begin errors++; $display("FAIL full_issues: got %0d expected 64", n_issue); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b expected 0", busy1); end
        checks++; if (n_busy_low != 0) begin errors++; $display("FAIL full_busy_gap: got %0d expected 0", n_busy_low); end
    endtask

    task automatic test_backpressure();
        bit ok;
        mon_clear();
        set_ready(1'b1);
        pulse_start(4'd3);
        wait_done(1, ok);
        set_ready(1'b1);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: done not seen"); end
        checks++; if (qd.size() != 64) begin errors++; $display("FAIL bp_beats: got %0d expected 64", qd.size()); end
        checks++; if (count_bad(4'd3) != 0) begin errors++; $display("FAIL bp_content: %0d bad beats expected 0", count_bad(4'd3)); end
        checks++; if (n_unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", n_unstable); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d expected 1", n_done); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        mon_clear();
        set_ready(1'b1);
        pulse_start(4'd3);
        repeat (8) @(posedge clk);
        #1; start1 = 1'b1; row_sel = 4'd5;
        @(posedge clk); #1; start1 = 1'b0;
        wait_done(0, ok);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL ign_timeout: done not seen"); end
        checks++; if (qd.size() != 64) begin errors++; $display("FAIL ign_beats: got %0d expected 64", qd.size()); end
        checks++; if (count_bad(4'd3) != 0) begin errors++; $display("FAIL ign_content: %0d bad beats expected 0", count_bad(4'd3)); end
        checks++; if (n_busy_low != 0) begin errors++; $display("FAIL ign_busy: busy low %0d cycles expected 0", n_busy_low); end
        checks++; if (n_issue != 64 || busy1 !== 1'b0) begin errors++; $display("FAIL ign_no_refetch: issues %0d busy %b expected 64/0", n_issue, busy1); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        mon_clear();
        set_ready(1'b1);
        pulse_start(4'd3);
        for (int c = 0; c < 200 && qd.size() < 20; c++) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({valid1, busy1, en1} !== 3'b000) begin errors++; $display("FAIL abort_async: got %b expected 000", {valid1, busy1, en1}); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (n_done != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", n_done); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL abort_late_ret: got %b expected 0", valid1); end
        mon_clear();
        pulse_start(4'd0);
        wait_done(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_timeout: done not seen"); end
        checks++; if (qd.size() != 64) begin errors++; $display("FAIL abort_beats: got %0d expected 64", qd.size()); end
        checks++; if (qc.size() > 0 && qc[0] !== exp_col(0)) begin errors++; $display("FAIL abort_first_col: got %0d expected %0d", qc[0], exp_col(0)); end
        checks++; if (count_bad(4'd0) != 0) begin errors++; $display("FAIL abort_content: %0d bad beats expected 0", count_bad(4'd0)); end
    endtask

    task automatic test_latency3();
        bit ok;
        sel3 = 1'b1;
        mon_clear();
        pix_ready3 = 1'b0;
        pulse_start(4'd7);
        repeat (9) @(posedge clk);
        #1;
        checks++; if (n_issue != 4) begin errors++; $display("FAIL l3_credit: got %0d reads expected 4", n_issue); end
        checks++; if (en3 !== 1'b0 || valid3 !== 1'b1) begin errors++; $display("FAIL l3_stall: en/valid got %b%b expected 01", en3, valid3); end
        checks++; if (qd.size() != 0) begin errors++; $display("FAIL l3_no_beats: got %0d expected 0", qd.size()); end
        wait_done(0, ok);
        checks++; if (!ok || qd.size() != 64) begin errors++; $display("FAIL l3_beats: got %0d expected 64", qd.size()); end
        checks++; if (count_bad(4'd7) != 0) begin errors++; $display("FAIL l3_content: %0d bad beats expected 0", count_bad(4'd7)); end
        checks++; if (n_issue != 64) begin errors++; $display("FAIL l3_issues: got %0d expected 64", n_issue); end
        mon_clear();
        pulse_start(4'd3);
        wait_done(0, ok);
        checks++; if (t_valid - t_start != 5) begin errors++; $display("FAIL l3_first_lat: got %0d expected 5", t_valid - t_start); end
        checks++; if (t_last - t_start != 68) begin errors++; $display("FAIL l3_last_lat: got %0d expected 68", t_last - t_start); end
        checks++; if (count_bad(4'd3) != 0 || qd.size() != 64) begin errors++; $display("FAIL l3_full: %0d bad of %0d beats expected 0 of 64", count_bad(4'd3), qd.size()); end
        sel3 = 1'b0;
    endtask

    task automatic test_order();
        bit ok;
        logic [9:0] exp_addr;
`ifdef FB_FETCH_MIRROR_EN
        exp_addr = 10'h3FF;
`else
        exp_addr = 10'h3C0;
`endif
        mon_clear();
        set_ready(1'b1);
        pulse_start(4'd15);
        wait_done(0, ok);
        checks++; if (first_addr !== exp_addr) begin errors++; $display("FAIL ord_first_addr: got %h expected %h", first_addr, exp_addr); end
        checks++; if (qc.size() > 0 && qc[0] !== exp_col(0)) begin errors++; $display("FAIL ord_first_col: got %0d expected %0d", qc[0], exp_col(0)); end
        checks++; if (qc.size() == 64 && (qc[63] !== exp_col(63) || ql[63] !== 1'b1)) begin errors++; $display("FAIL ord_last: got %0d/%b expected %0d/1", qc[63], ql[63], exp_col(63)); end
        checks++; if (!ok || qd.size() != 64 || count_bad(4'd15) != 0) begin errors++; $display("FAIL ord_content: %0d beats, %0d bad, expected 64/0", qd.size(), count_bad(4'd15)); end
    endtask

    initial begin
        reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0; row_sel = '0; row_sel_dummy = 1'b0;
        pix_ready1 = 1'b1; pix_ready3 = 1'b1;
        mon_clear();
        for (int a = 0; a < 1024; a++) mem[a] = exp_word(4'(a >> 6), 6'(a));
        #23;
        test_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        test_full_row();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        test_latency3();
        test_order();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
